// File: rtl/t_ff.sv
// Toggle flip-flop with asynchronous active-high clear.
// Latency: Q updates on the same rising edge that samples T (single register, no pipeline).
// Backpressure: none; T is sampled on every edge and there is no handshake.
//
// Ports:
//   Clk   - clock; state changes on the rising edge
//   Reset - asynchronous active-high clear (Q=0, Qbar=1 at once)
//   T     - toggle enable, sampled on the Clk rising edge
//   Q     - stored state
//   Qbar  - complement of the stored state
module t_ff (
    input  logic Clk,
    input  logic Reset,
    input  logic T,
    output logic Q,
    output logic Qbar
);

    logic state;

    // Reset sits in the sensitivity list, so it clears the state without a clock edge
    // and wins over a coincident rising edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= 1'b0;
        end else if (T) begin
            state <= ~state;
        end
    end

    // Both outputs come straight from the register, so T has no combinational path to them
    // and Qbar tracks Q even while Reset is held.
    assign Q    = state;
    assign Qbar = ~state;

endmodule

// File: tb/tb_t_ff.sv
`timescale 1ns/1ps
module tb_t_ff;

    logic Clk;
    logic Reset;
    logic T;
    logic Q;
    logic Qbar;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: Q is the parity of the number of rising edges, since the
    // last reset, on which T was 1.
    int toggles = 0;

    t_ff dut (
        .Clk  (Clk),
        .Reset(Reset),
        .T    (T),
        .Q    (Q),
        .Qbar (Qbar)
    );

    // 200 ns period, first rising edge at 100 ns.
    initial begin
        Clk = 1'b0;
        forever #100 Clk = ~Clk;
    end

    function automatic logic exp_q();
        return logic'(toggles % 2);
    endfunction

    // Wait for a rising edge, update the model from the values present at that edge,
    // then move 1 ns past it so outputs are sampled away from the edge.
    task automatic step();
        logic t_at_edge;
        logic r_at_edge;
        @(posedge Clk);
        t_at_edge = T;
        r_at_edge = Reset;
        if (r_at_edge)
            toggles = 0;
        else if (t_at_edge)
            toggles = toggles + 1;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        T     = 1'b0;
        #1 Reset = 1'b1;
        toggles = 0;
        #0.5;
        n_tests++;
        if (Q !== 1'b0 || Qbar !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_assert: Q=%b Qbar=%b, required Q=0 Qbar=1", Q, Qbar);
        end
        #0.5 Reset = 1'b0;
        #0.5;
        n_tests++;
        if (Q !== 1'b0 || Qbar !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: Q=%b Qbar=%b, required Q=0 Qbar=1", Q, Qbar);
        end
    endtask

    task automatic test_hold_after_reset();
        T = 1'b0;
        step();
        n_tests++;
        if (Q !== 1'b0 || Qbar !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_first_edge: Q=%b Qbar=%b, required Q=0 Qbar=1", Q, Qbar);
        end
    endtask

    task automatic test_toggle();
        @(negedge Clk);
        T = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (Q !== exp_q() || Qbar !== ~exp_q()) begin
                n_fail++;
                $display("FAIL toggle_edge%0d: Q=%b Qbar=%b, required Q=%b", i, Q, Qbar, exp_q());
            end
        end
        // Leave Q=1 for the next scenario.
        step();
        n_tests++;
        if (Q !== 1'b1 || Qbar !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_to_one: Q=%b Qbar=%b, required Q=1 Qbar=0", Q, Qbar);
        end
    endtask

    task automatic test_hold_and_glitch();
        @(negedge Clk);
        T = 1'b0;
        step();
        n_tests++;
        if (Q !== 1'b1 || Qbar !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_one: Q=%b Qbar=%b, required Q=1 Qbar=0", Q, Qbar);
        end
        // T pulse entirely between edges must not change Q.
        @(negedge Clk);
        #25 T = 1'b1;
        #50 T = 1'b0;
        step();
        n_tests++;
        if (Q !== 1'b1 || Qbar !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_ignored: Q=%b Qbar=%b, required Q=1 Qbar=0", Q, Qbar);
        end
    endtask

    task automatic test_toggle_then_hold();
        @(negedge Clk);
        T = 1'b1;
        step();
        n_tests++;
        if (Q !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_then_hold_a: Q=%b, required 0", Q);
        end
        @(negedge Clk);
        T = 1'b0;
        step();
        n_tests++;
        if (Q !== 1'b0 || Qbar !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_then_hold_b: Q=%b Qbar=%b, required Q=0 Qbar=1", Q, Qbar);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge Clk);
        T = 1'b1;
        step();
        n_tests++;
        if (Q !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_setup: Q=%b, required 1", Q);
        end
        #49 Reset = 1'b1;
        toggles = 0;
        #1;
        n_tests++;
        if (Q !== 1'b0 || Qbar !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_immediate: Q=%b Qbar=%b, required Q=0 Qbar=1", Q, Qbar);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (Q !== 1'b0 || Qbar !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_held_edge%0d: Q=%b Qbar=%b, required Q=0 Qbar=1", i, Q, Qbar);
            end
        end
        @(negedge Clk);
        Reset = 1'b0;
        step();
        n_tests++;
        if (Q !== 1'b1 || Qbar !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge_after_reset: Q=%b Qbar=%b, required Q=1 Qbar=0", Q, Qbar);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            T = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                #30 Reset = 1'b1;
                toggles = 0;
                #1;
                n_tests++;
                if (Q !== 1'b0 || Qbar !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random_reset%0d: Q=%b Qbar=%b, required Q=0 Qbar=1", i, Q, Qbar);
                end
                #10 Reset = 1'b0;
            end
            step();
            n_tests++;
            if (Q !== exp_q() || Qbar !== ~exp_q()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: Q=%b Qbar=%b, required Q=%b", i, Q, Qbar, exp_q());
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_after_reset();
        test_toggle();
        test_hold_and_glitch();
        test_toggle_then_hold();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
